// File: rtl/ts_os_detector_if.sv
// ts_os_detector_if: per-lane symbol inputs, counter clear and decoded ordered-set outputs
interface ts_os_detector_if #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W = 4
);
  logic [NUM_LANES-1:0] sym_valid;
  logic [NUM_LANES*8-1:0] sym_data;
  logic [NUM_LANES-1:0] sym_k;
  logic clear_cnt;
  logic [NUM_LANES-1:0] os_valid;
  logic [NUM_LANES-1:0] os_err;
  logic [NUM_LANES-1:0] os_is_ts2;
  logic [NUM_LANES*8-1:0] os_link;
  logic [NUM_LANES*8-1:0] os_lane;
  logic [NUM_LANES-1:0] os_link_pad;
  logic [NUM_LANES-1:0] os_lane_pad;
  logic [NUM_LANES*8-1:0] os_nfts;
  logic [NUM_LANES*8-1:0] os_rate;
  logic [NUM_LANES*8-1:0] os_ctrl;
  logic [NUM_LANES*CNT_W-1:0] consec_cnt;
  logic [NUM_LANES-1:0] consec_done;
  logic all_done;
  modport master (
    output sym_valid, sym_data, sym_k, clear_cnt,
    input os_valid, os_err, os_is_ts2, os_link, os_lane, os_link_pad, os_lane_pad,
    input os_nfts, os_rate, os_ctrl, consec_cnt, consec_done, all_done
  );
  modport slave (
    input sym_valid, sym_data, sym_k, clear_cnt,
    output os_valid, os_err, os_is_ts2, os_link, os_lane, os_link_pad, os_lane_pad,
    output os_nfts, os_rate, os_ctrl, consec_cnt, consec_done, all_done
  );
endinterface

// File: rtl/ts_os_detector.sv
// ts_os_detector: per-lane TS1/TS2 ordered-set assembly, validation and consecutive-match counting
module ts_os_detector #(
  parameter int NUM_LANES = 4,
  parameter int CONSEC_CNT = 8,
  parameter int CNT_W = 4,
  parameter logic [7:0] COM_SYM = 8'hBC,
  parameter logic [7:0] PAD_SYM = 8'hF7,
  parameter logic [7:0] TS1_ID = 8'h4A,
  parameter logic [7:0] TS2_ID = 8'h45
) (
  input logic clk,
  input logic rst,
  ts_os_detector_if.slave bus
);
  typedef enum logic {HUNT, COLLECT} state_t;
  logic [NUM_LANES-1:0] done;
  assign bus.consec_done = done;
  assign bus.all_done = &done;
  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : lane
      logic [7:0] d;
      logic k, v;
      logic is_com, is_pad, ok, same;
      logic [42:0] key;
      state_t st;
      logic [3:0] idx;
      logic [7:0] s_link, s_lane, s_nfts, s_rate, s_ctrl;
      logic s_lpad, s_npad, s_ts2;
      logic r_v;
      logic [42:0] r_key;
      logic val, err, o_ts2, o_lpad, o_npad;
      logic [7:0] o_link, o_lane, o_nfts, o_rate, o_ctrl;
      logic [CNT_W-1:0] cnt;
      assign d = bus.sym_data[8*g +: 8];
      assign k = bus.sym_k[g];
      assign v = bus.sym_valid[g];
      // symbol legality by position and comparison of the assembled set against the stored reference
      always_comb begin
        is_com = k && d == COM_SYM;
        is_pad = k && d == PAD_SYM;
        ok = idx <= 4'd2 ? (!k || is_pad) :
             idx <= 4'd5 ? !k :
             idx == 4'd6 ? (!k && (d == TS1_ID || d == TS2_ID)) :
             (!k && d == (s_ts2 ? TS2_ID : TS1_ID));
        key = {s_ts2, s_link, s_lane, s_lpad, s_npad, s_nfts, s_rate, s_ctrl};
        same = r_v && key == r_key;
      end
      // lane FSM, shadow capture, registered outputs and consecutive counter; clear overrides a completing set
      always_ff @(posedge clk) begin
        if (rst) begin
          st <= HUNT;
          idx <= '0;
          {s_link, s_lane, s_nfts, s_rate, s_ctrl, s_lpad, s_npad, s_ts2} <= '0;
          r_v <= 1'b0;
          r_key <= '0;
          {val, err, o_ts2, o_lpad, o_npad} <= '0;
          {o_link, o_lane, o_nfts, o_rate, o_ctrl} <= '0;
          cnt <= '0;
        end else begin
          val <= 1'b0;
          err <= 1'b0;
          if (v) begin
            if (st == HUNT) begin
              if (is_com) begin
                st <= COLLECT;
                idx <= 4'd1;
              end
            end else if (!ok) begin
              err <= 1'b1;
              st <= is_com ? COLLECT : HUNT;
              idx <= 4'd1;
            end else begin
              idx <= idx + 4'd1;
              if (idx == 4'd1) begin
                s_link <= d;
                s_lpad <= is_pad;
              end
              if (idx == 4'd2) begin
                s_lane <= d;
                s_npad <= is_pad;
              end
              if (idx == 4'd3) s_nfts <= d;
              if (idx == 4'd4) s_rate <= d;
              if (idx == 4'd5) s_ctrl <= d;
              if (idx == 4'd6) s_ts2 <= d == TS2_ID;
              if (idx == 4'd15) begin
                st <= HUNT;
                val <= 1'b1;
                {o_ts2, o_link, o_lane, o_lpad, o_npad, o_nfts, o_rate, o_ctrl} <= key;
                cnt <= !same ? CNT_W'(1) : cnt == CNT_W'(CONSEC_CNT) ? cnt : cnt + CNT_W'(1);
                r_v <= 1'b1;
                r_key <= key;
              end
            end
          end
          if (bus.clear_cnt) begin
            cnt <= '0;
            r_v <= 1'b0;
          end
        end
      end
      assign bus.os_valid[g] = val;
      assign bus.os_err[g] = err;
      assign bus.os_is_ts2[g] = o_ts2;
      assign bus.os_link[8*g +: 8] = o_link;
      assign bus.os_lane[8*g +: 8] = o_lane;
      assign bus.os_link_pad[g] = o_lpad;
      assign bus.os_lane_pad[g] = o_npad;
      assign bus.os_nfts[8*g +: 8] = o_nfts;
      assign bus.os_rate[8*g +: 8] = o_rate;
      assign bus.os_ctrl[8*g +: 8] = o_ctrl;
      assign bus.consec_cnt[CNT_W*g +: CNT_W] = cnt;
      assign done[g] = cnt == CNT_W'(CONSEC_CNT);
    end
  endgenerate
endmodule
